mem_port_ctrl: RTL and testbench

Sequencer and arbiter for the single unified memory port of the pipelined y86-64 core. It shares the port between the fetch stage, which needs a 10-byte instruction read done as two 64-bit beats, and the memory stage, which needs an 8-byte read or write decoded from `M_icode`. It drives the pipeline stall requests while either stage waits on memory. It sits between the F/M pipeline stages and the memory model and owns every memory-port transaction.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/mem_op_decode.sv | 33 +++
 rtl/mem_port_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared y86-64 definitions for the memory-port sequencer: icodes, port FSM
// states, address width and the address range helper.
package y86_pkg;

    localparam int ADDR_W = 64;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MACC,
        S_FB0,
        S_FB1
    } port_state_t;

    // One extra bit so that an access wrapping past 2^64 is out of range.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W:0]   len,
                                      input logic [ADDR_W:0]   limit);
        return ({1'b0, addr} + len) <= limit;
    endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Memory-stage icode decode: whether an access is needed, its direction and
// which operand (valE when addr_sel=1, valA otherwise) carries the address.
module mem_op_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       m_req,
    output logic       we,
    output logic       addr_sel
);

    always_comb begin
        m_req    = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        case (icode)
            IRMMOVQ, ICALL, IPUSHQ: begin
                m_req    = 1'b1;
                we       = 1'b1;
                addr_sel = 1'b1;
            end
            IMRMOVQ: begin
                m_req    = 1'b1;
                addr_sel = 1'b1;
            end
            IRET, IPOPQ: begin
                m_req    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Unified memory port sequencer: arbitrates the fetch stage (two-beat 10-byte
// read) and the memory stage (single 8-byte access) onto one handshake port.
module mem_port_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [63:0] f_pc,
    output logic        f_done,
    output logic [79:0] f_instr,
    output logic        f_err,
    output logic        f_stall,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valA,
    input  logic [63:0] M_valE,
    output logic        m_done,
    output logic [63:0] m_valM,
    output logic        m_err,
    output logic        m_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        mem_err
);

    localparam logic [ADDR_W:0] LIMIT = 65'(MEM_BYTES);

    port_state_t state, state_nxt;
    logic        last_m, last_m_nxt;
    logic        mem_req_nxt, mem_we_nxt;
    logic [63:0] mem_addr_nxt, mem_wdata_nxt;
    logic        f_done_nxt, f_err_nxt, m_done_nxt, m_err_nxt;
    logic [79:0] f_instr_nxt;
    logic [63:0] m_valM_nxt;

    logic        m_req, dec_we, dec_addr_sel;
    logic [63:0] m_addr;
    logic        m_ok, f_ok;
    logic        m_go, f_go, grant_m, grant_f;

    mem_op_decode u_dec (
        .icode    (M_icode),
        .m_req    (m_req),
        .we       (dec_we),
        .addr_sel (dec_addr_sel)
    );

    assign m_addr = dec_addr_sel ? M_valE : M_valA;
    assign m_ok   = in_range(m_addr, 65'd8, LIMIT);
    assign f_ok   = in_range(f_pc, 65'd10, LIMIT);

    assign f_stall = f_req & ~f_done;
    assign m_stall = m_req & ~m_done;

    // A requester whose done is pulsing still holds its request for that
    // cycle; masking it here prevents the same access being granted twice.
    assign m_go    = m_stall;
    assign f_go    = f_stall;
    assign grant_m = m_go & (~f_go | ~last_m);
    assign grant_f = f_go & ~grant_m;

    always_comb begin
        state_nxt     = state;
        last_m_nxt    = last_m;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        f_done_nxt    = 1'b0;
        f_instr_nxt   = f_instr;
        f_err_nxt     = f_err;
        m_done_nxt    = 1'b0;
        m_valM_nxt    = m_valM;
        m_err_nxt     = m_err;

        case (state)
            S_IDLE: begin
                if (grant_m) begin
                    if (m_ok) begin
                        state_nxt     = S_MACC;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = dec_we;
                        mem_addr_nxt  = m_addr;
                        mem_wdata_nxt = M_valA;
                    end else begin
                        m_done_nxt = 1'b1;
                        m_err_nxt  = 1'b1;
                        m_valM_nxt = '0;
                        last_m_nxt = 1'b1;
                    end
                end else if (grant_f) begin
                    if (f_ok) begin
                        state_nxt     = S_FB0;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = f_pc;
                        mem_wdata_nxt = '0;
                    end else begin
                        f_done_nxt  = 1'b1;
                        f_err_nxt   = 1'b1;
                        f_instr_nxt = '0;
                        last_m_nxt  = 1'b0;
                    end
                end
            end
            S_MACC: begin
                if (mem_ack) begin
                    state_nxt   = S_IDLE;
                    mem_req_nxt = 1'b0;
                    m_done_nxt  = 1'b1;
                    m_err_nxt   = mem_err;
                    m_valM_nxt  = mem_we ? 64'h0 : mem_rdata;
                    last_m_nxt  = 1'b1;
                end
            end
            S_FB0: begin
                if (mem_ack) begin
                    f_instr_nxt[63:0] = mem_rdata;
                    if (mem_err) begin
                        state_nxt          = S_IDLE;
                        mem_req_nxt        = 1'b0;
                        f_done_nxt         = 1'b1;
                        f_err_nxt          = 1'b1;
                        f_instr_nxt[79:64] = '0;
                        last_m_nxt         = 1'b0;
                    end else begin
                        // Second beat follows immediately; mem_req stays high.
                        state_nxt    = S_FB1;
                        mem_addr_nxt = mem_addr + 64'd8;
                    end
                end
            end
            S_FB1: begin
                if (mem_ack) begin
                    state_nxt          = S_IDLE;
                    mem_req_nxt        = 1'b0;
                    f_done_nxt         = 1'b1;
                    f_err_nxt          = mem_err;
                    f_instr_nxt[79:64] = mem_rdata[15:0];
                    last_m_nxt         = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last_m    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_done    <= 1'b0;
            f_instr   <= '0;
            f_err     <= 1'b0;
            m_done    <= 1'b0;
            m_valM    <= '0;
            m_err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_m    <= last_m_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            f_done    <= f_done_nxt;
            f_instr   <= f_instr_nxt;
            f_err     <= f_err_nxt;
            m_done    <= m_done_nxt;
            m_valM    <= m_valM_nxt;
            m_err     <= m_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: byte-array reference memory, a
// variable-latency memory responder and per-stage expected-result queues.
module tb_mem_port_ctrl;

    localparam int MEM_BYTES = 8192;

    typedef struct {
        logic [79:0] data;
        logic        err;
        logic        cmp_data;
    } exp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [63:0] f_pc;
    logic        f_done;
    logic [79:0] f_instr;
    logic        f_err;
    logic        f_stall;
    logic [3:0]  M_icode;
    logic [63:0] M_valA;
    logic [63:0] M_valE;
    logic        m_done;
    logic [63:0] m_valM;
    logic        m_err;
    logic        m_stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        exp_m[$];
    exp_t        exp_f[$];
    beat_t       log_q[$];
    int          lat_q[$];
    int          fix_lat;
    bit          inject_err;
    logic [7:0]  phys    [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [3:0]  nm_list [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hC, 4'hF};

    mem_port_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_pc      (f_pc),
        .f_done    (f_done),
        .f_instr   (f_instr),
        .f_err     (f_err),
        .f_stall   (f_stall),
        .M_icode   (M_icode),
        .M_valA    (M_valA),
        .M_valE    (M_valE),
        .m_done    (m_done),
        .m_valM    (m_valM),
        .m_err     (m_err),
        .m_stall   (m_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [79:0] ref_rd(input logic [63:0] a, input int n);
        logic [79:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a[12:0]) + k];
        return v;
    endfunction

    function automatic exp_t ref_m(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve);
        exp_t        e;
        logic [63:0] a;
        bit          wr;
        wr = (ic == 4'd4 || ic == 4'd8 || ic == 4'd10);
        a  = (ic == 4'd9 || ic == 4'd11) ? va : ve;
        if (a > 64'(MEM_BYTES - 8)) begin
            e = '{80'h0, 1'b1, 1'b1};
        end else if (wr) begin
            for (int k = 0; k < 8; k++) ref_mem[int'(a[12:0]) + k] = va[8*k +: 8];
            e = '{80'h0, 1'b0, 1'b1};
        end else begin
            e = '{ref_rd(a, 8), 1'b0, 1'b1};
        end
        return e;
    endfunction

    function automatic exp_t ref_f(input logic [63:0] pc);
        exp_t e;
        if (pc > 64'(MEM_BYTES - 10)) e = '{80'h0, 1'b1, 1'b1};
        else e = '{ref_rd(pc, 10), 1'b0, 1'b1};
        return e;
    endfunction

    task automatic preload(input int a, input logic [63:0] w);
        for (int k = 0; k < 8; k++) begin
            phys[a + k]    = w[8*k +: 8];
            ref_mem[a + k] = w[8*k +: 8];
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin : mem_model
        logic        we_s;
        logic [63:0] a_s, d_s, rd;
        int          lat, idx;
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                we_s = mem_we; a_s = mem_addr; d_s = mem_wdata;
                log_q.push_back('{we_s, a_s, d_s});
                chk("beat_addr_in_mem", 80'(a_s < 64'(MEM_BYTES)), 80'd1);
                if (lat_q.size() > 0) lat = lat_q.pop_front();
                else if (fix_lat > 0) lat = fix_lat;
                else lat = $urandom_range(1, 3);
                repeat (lat) @(posedge clk);
                #1;
                rd = '0;
                for (int k = 0; k < 8; k++) begin
                    idx = int'(a_s[12:0]) + k;
                    if (a_s < 64'(MEM_BYTES) && idx < MEM_BYTES) begin
                        if (we_s) phys[idx] = d_s[8*k +: 8];
                        else rd[8*k +: 8] = phys[idx];
                    end
                end
                mem_rdata  = we_s ? {$urandom, $urandom} : rd;
                mem_err    = inject_err;
                inject_err = 1'b0;
                mem_ack    = 1'b1;
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_err   = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t em, ef;
        if (m_done === 1'b1) begin
            if (exp_m.size() == 0) begin
                chk("m_done_unexpected", 80'(m_done), 80'd0);
            end else begin
                em = exp_m.pop_front();
                chk("m_err", 80'(m_err), 80'(em.err));
                if (em.cmp_data) chk("m_valM", {16'h0, m_valM}, em.data);
            end
        end
        if (f_done === 1'b1) begin
            if (exp_f.size() == 0) begin
                chk("f_done_unexpected", 80'(f_done), 80'd0);
            end else begin
                ef = exp_f.pop_front();
                chk("f_err", 80'(f_err), 80'(ef.err));
                if (ef.cmp_data) chk("f_instr", f_instr, ef.data);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic m_issue(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                           output int lat, output int st);
        int t0;
        bit seen;
        exp_m.push_back(ref_m(ic, va, ve));
        M_icode = ic; M_valA = va; M_valE = ve;
        t0 = cyc; st = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (m_stall) st++;
            if (m_done) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL m_done_timeout: icode %0d got no m_done, expected one within 400 cycles", ic);
        end
        lat = cyc - t0;
        @(posedge clk);
        #1;
        M_icode = 4'h0;
    endtask

    task automatic f_issue(input logic [63:0] pc, input bit force_err, output int lat, output int st);
        exp_t e;
        int   t0;
        bit   seen;
        if (force_err) e = '{80'h0, 1'b1, 1'b0};
        else e = ref_f(pc);
        exp_f.push_back(e);
        f_pc = pc; f_req = 1'b1;
        t0 = cyc; st = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (f_stall) st++;
            if (f_done) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL f_done_timeout: pc 0x%0h got no f_done, expected one within 400 cycles", pc);
        end
        lat = cyc - t0;
        @(posedge clk);
        #1;
        f_req = 1'b0;
    endtask

    task automatic rand_m_op(output logic [3:0] ic, output logic [63:0] va, output logic [63:0] ve);
        logic [3:0]  ops [6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        logic [63:0] a, r;
        ic = ops[$urandom_range(0, 5)];
        r  = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0:       a = 64'(MEM_BYTES - 7 + int'($urandom_range(0, 6)));
            1:       a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            default: a = 64'(4096 + int'($urandom_range(0, 4088)));
        endcase
        if (ic == 4'd9 || ic == 4'd11) begin va = a; ve = r; end
        else begin va = r; ve = a; end
    endtask

    task automatic rand_pc(output logic [63:0] pc);
        case ($urandom_range(0, 9))
            0:       pc = 64'(MEM_BYTES - 9 + int'($urandom_range(0, 8)));
            1:       pc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            default: pc = 64'($urandom_range(0, 4086));
        endcase
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running after 50000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int l1, s1, l2, s2;
        bit seen;
        rst = 1'b1; f_req = 1'b1; f_pc = '0;
        M_icode = 4'h0; M_valA = '0; M_valE = '0;
        fix_lat = 1; inject_err = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            phys[i]    = 8'($urandom);
            ref_mem[i] = phys[i];
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req",   80'(mem_req),   80'd0);
        chk("rst_mem_we",    80'(mem_we),    80'd0);
        chk("rst_mem_addr",  80'(mem_addr),  80'd0);
        chk("rst_mem_wdata", 80'(mem_wdata), 80'd0);
        chk("rst_f_done",    80'(f_done),    80'd0);
        chk("rst_m_done",    80'(m_done),    80'd0);
        chk("rst_f_instr",   f_instr,        80'd0);
        chk("rst_m_valM",    80'(m_valM),    80'd0);
        chk("rst_f_err",     80'(f_err),     80'd0);
        chk("rst_m_err",     80'(m_err),     80'd0);
        chk("rst_f_stall",   80'(f_stall),   80'd1);
        chk("rst_m_stall",   80'(m_stall),   80'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; f_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // rmmovq write, 1-cycle memory
        log_q.delete();
        m_issue(4'd4, 64'd66, 64'd62, l1, s1);
        chk("wr_latency", 80'(l1), 80'd3);
        chk("wr_stall_cycles", 80'(s1), 80'd3);
        chk("wr_beats", 80'(log_q.size()), 80'd1);
        if (log_q.size() > 0) begin
            chk("wr_we",   80'(log_q[0].we),   80'd1);
            chk("wr_addr", 80'(log_q[0].addr), 80'd62);
            chk("wr_data", 80'(log_q[0].data), 80'd66);
        end

        // popq and mrmovq reads of the same word
        preload(62, 64'd66);
        log_q.delete();
        m_issue(4'd11, 64'd62, 64'd0, l1, s1);
        chk("popq_latency", 80'(l1), 80'd3);
        chk("popq_valM", 80'(m_valM), 80'd66);
        m_issue(4'd5, 64'h0, 64'd62, l1, s1);
        chk("mrmovq_valM", 80'(m_valM), 80'd66);
        chk("rd_beats", 80'(log_q.size()), 80'd2);
        if (log_q.size() > 1) begin
            chk("popq_addr",   80'(log_q[0].addr), 80'd62);
            chk("mrmovq_addr", 80'(log_q[1].addr), 80'd62);
            chk("mrmovq_we",   80'(log_q[1].we),   80'd0);
        end

        // two-beat fetch
        preload(16, 64'h1122334455667788);
        preload(24, 64'h0123456789AB_AABB);
        log_q.delete();
        f_issue(64'd16, 1'b0, l1, s1);
        chk("fetch_latency", 80'(l1), 80'd5);
        chk("fetch_stall_cycles", 80'(s1), 80'd5);
        chk("fetch_instr_const", f_instr, 80'hAABB_1122334455667788);
        chk("fetch_beats", 80'(log_q.size()), 80'd2);
        if (log_q.size() > 1) begin
            chk("fetch_beat0_addr", 80'(log_q[0].addr), 80'd16);
            chk("fetch_beat1_addr", 80'(log_q[1].addr), 80'd24);
        end

        // simultaneous requests, memory stage re-requests after completing
        log_q.delete();
        fork
            begin
                m_issue(4'd5, 64'h0, 64'd4200, l1, s1);
                m_issue(4'd4, 64'hDEAD_BEEF_0BAD_F00D, 64'd4300, l1, s1);
            end
            f_issue(64'd100, 1'b0, l2, s2);
        join
        chk("fair_beats", 80'(log_q.size()), 80'd4);
        if (log_q.size() > 3) begin
            chk("fair_order0", 80'(log_q[0].addr), 80'd4200);
            chk("fair_order1", 80'(log_q[1].addr), 80'd100);
            chk("fair_order2", 80'(log_q[2].addr), 80'd108);
            chk("fair_order3", 80'(log_q[3].addr), 80'd4300);
        end

        // out-of-range accesses never reach the port
        log_q.delete();
        m_issue(4'd10, 64'd5, 64'd8190, l1, s1);
        chk("oor_latency", 80'(l1), 80'd1);
        m_issue(4'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, l1, s1);
        f_issue(64'd8183, 1'b0, l1, s1);
        chk("oor_beats", 80'(log_q.size()), 80'd0);

        // error on first fetch beat: single beat, f_err
        log_q.delete();
        inject_err = 1'b1;
        f_issue(64'd200, 1'b1, l1, s1);
        chk("ferr_beats", 80'(log_q.size()), 80'd1);

        // randomized concurrent traffic, latency 1..3
        fix_lat = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [3:0]  ic;
                    logic [63:0] va, ve;
                    int          lm, sm;
                    repeat ($urandom_range(0, 3)) begin
                        M_icode = nm_list[$urandom_range(0, 7)];
                        @(posedge clk);
                        #1;
                    end
                    rand_m_op(ic, va, ve);
                    m_issue(ic, va, ve, lm, sm);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [63:0] pc;
                    int          lf, sf;
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk);
                        #1;
                    end
                    rand_pc(pc);
                    f_issue(pc, 1'b0, lf, sf);
                end
            end
        join
        fix_lat = 1;
        repeat (3) @(posedge clk);
        #1;

        // reset while the second fetch beat is outstanding
        log_q.delete();
        lat_q.push_back(1);
        lat_q.push_back(6);
        f_pc = 64'd300; f_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 64'd308) seen = 1;
        end
        chk("rst_fb1_reached", 80'(seen), 80'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; f_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_req",  80'(mem_req),  80'd0);
        chk("rst_mid_mem_addr", 80'(mem_addr), 80'd0);
        chk("rst_mid_f_instr",  f_instr,       80'd0);
        repeat (10) begin
            @(negedge clk);
            chk("late_ack_mem_req", 80'(mem_req), 80'd0);
            chk("late_ack_f_done",  80'(f_done),  80'd0);
        end

        chk("exp_m_drained", 80'(exp_m.size()), 80'd0);
        chk("exp_f_drained", 80'(exp_f.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
